dcache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the processor MEM stage (upstream) and the byte-addressed, big-endian main memory (downstream).
- Read hits are served in one cycle. Read misses and all writes are forwarded to main memory over a fixed-latency window, and the CPU is stalled for that window.
- Lines are one 32-bit word. Accesses are word-aligned only; address bits [1:0] are ignored and driven as 00 toward memory.

---
 rtl/dcache_controller.sv | 167 ++++++++++++++++
 tb/tb_dcache_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits answer combinationally; read misses and all writes stall the CPU for a fixed memory window.
module dcache_controller #(
  parameter int INDEX_BITS  = 6,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpuAddress,
  input  logic        cpuRead,
  input  logic        cpuWrite,
  input  logic [31:0] cpuDataIn,
  output logic [31:0] cpuDataOut,
  output logic        cpuStall,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memDataOut,
  input  logic [31:0] memDataIn
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        result_q, result_d;
  logic               rd_q, rd_d;
  logic [LINES-1:0]   valid_q;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [INDEX_BITS-1:0] req_index, lat_index;
  logic [TAG_W-1:0]      req_tag, lat_tag;
  logic                  hit, last_cycle, wr_hit, fill;
  logic                  unused_addr_bits;

  assign req_index        = cpuAddress[INDEX_BITS+1:2];
  assign req_tag          = cpuAddress[31:INDEX_BITS+2];
  assign lat_index        = addr_q[INDEX_BITS+1:2];
  assign lat_tag          = addr_q[31:INDEX_BITS+2];
  assign hit              = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign last_cycle       = (cnt_q == CNT_W'(MEM_LATENCY - 1));
  assign unused_addr_bits = ^cpuAddress[1:0];

  // Memory side is driven only from latched registers so it stays stable for the whole window.
  assign memAddress = addr_q;
  assign memDataOut = data_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    data_d         = data_q;
    result_d       = result_q;
    rd_d           = rd_q;
    cpuStall       = 1'b0;
    cpuDataOut     = 32'h0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    wr_hit         = 1'b0;
    fill           = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpuRead) begin
          // A simultaneous write is dropped: the access is a plain read.
          if (hit) begin
            cpuDataOut = data_mem[req_index];
          end else begin
            cpuStall = 1'b1;
            addr_d   = {cpuAddress[31:2], 2'b00};
            rd_d     = 1'b1;
            cnt_d    = '0;
            state_d  = RD_MISS;
          end
        end else if (cpuWrite) begin
          cpuStall = 1'b1;
          addr_d   = {cpuAddress[31:2], 2'b00};
          data_d   = cpuDataIn;
          rd_d     = 1'b0;
          wr_hit   = hit;
          cnt_d    = '0;
          state_d  = WR_THRU;
        end
      end
      RD_MISS: begin
        cpuStall      = 1'b1;
        memReadEnable = 1'b1;
        if (last_cycle) begin
          fill     = 1'b1;
          result_d = memDataIn;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_THRU: begin
        cpuStall       = 1'b1;
        memWriteEnable = 1'b1;
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cpuDataOut = rd_q ? result_q : 32'h0;
        cnt_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is held the CPU sees an idle, non-stalling cache.
    if (reset) begin
      cpuStall   = 1'b0;
      cpuDataOut = 32'h0;
      wr_hit     = 1'b0;
      fill       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      result_q <= 32'h0;
      rd_q     <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      if (fill) begin
        valid_q[lat_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_mem[req_index] <= cpuDataIn;
    end
    if (fill) begin
      data_mem[lat_index] <= memDataIn;
      tag_mem[lat_index]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a big-endian byte memory model.
`timescale 1ns/1ps
module tb_dcache_controller;

  logic        clk;
  logic        reset;
  logic [31:0] cpuAddress;
  logic        cpuRead;
  logic        cpuWrite;
  logic [31:0] cpuDataIn;
  logic [31:0] cpuDataOut;
  logic        cpuStall;
  logic [31:0] memAddress;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:4095];

  dcache_controller #(.INDEX_BITS(6), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .cpuAddress(cpuAddress), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuStall(cpuStall),
    .memAddress(memAddress), .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable), .memDataOut(memDataOut),
    .memDataIn(memDataIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    memDataIn = {mem[{memAddress[11:2], 2'd0}], mem[{memAddress[11:2], 2'd1}],
                 mem[{memAddress[11:2], 2'd2}], mem[{memAddress[11:2], 2'd3}]};
  end

  // Main memory blocks writes while its read enable is high.
  always @(posedge clk) begin
    if (memWriteEnable && !memReadEnable) begin
      mem[{memAddress[11:2], 2'd0}] <= memDataOut[31:24];
      mem[{memAddress[11:2], 2'd1}] <= memDataOut[23:16];
      mem[{memAddress[11:2], 2'd2}] <= memDataOut[15:8];
      mem[{memAddress[11:2], 2'd3}] <= memDataOut[7:0];
    end
  end

  function automatic logic [31:0] get_word(input logic [31:0] a);
    return {mem[{a[11:2], 2'd0}], mem[{a[11:2], 2'd1}], mem[{a[11:2], 2'd2}], mem[{a[11:2], 2'd3}]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    mem[{a[11:2], 2'd0}] = v[31:24];
    mem[{a[11:2], 2'd1}] = v[23:16];
    mem[{a[11:2], 2'd2}] = v[15:8];
    mem[{a[11:2], 2'd3}] = v[7:0];
  endtask

  // Presents one request right after a clock edge and holds it until the stall is released.
  task automatic do_access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d,
                           output int stalls, output int rds, output int wrs,
                           output logic [31:0] dout, output logic [31:0] maddr,
                           output logic [31:0] mdata, output logic both);
    int cyc;
    stalls = 0; rds = 0; wrs = 0; dout = 32'h0; maddr = 32'h0; mdata = 32'h0; both = 1'b0;
    cpuAddress = a; cpuRead = rd; cpuWrite = wr; cpuDataIn = d;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (memReadEnable)  begin rds++; maddr = memAddress; end
      if (memWriteEnable) begin wrs++; maddr = memAddress; mdata = memDataOut; end
      if (memReadEnable && memWriteEnable) both = 1'b1;
      if (!cpuStall) begin
        dout = cpuDataOut;
        break;
      end
      stalls++;
      cyc++;
      if (cyc > 20) begin
        checks++; errors++;
        $display("FAIL access_timeout addr=%h: stall still 1 after %0d cycles, required release", a, cyc);
        break;
      end
    end
    @(posedge clk);
    #1;
    cpuRead = 1'b0; cpuWrite = 1'b0; cpuAddress = 32'h0; cpuDataIn = 32'h0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    cpuAddress = 32'h0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuDataIn = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cpuStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, expected 0", cpuStall); end
    checks++; if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_enables: got rd=%b wr=%b, expected 0/0", memReadEnable, memWriteEnable); end
    checks++; if (memAddress !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h, expected 0", memAddress); end
    checks++; if (cpuDataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout: got %h, expected 0", cpuDataOut); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_read_miss();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    do_access(32'h40, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000040 miss: stalls=%0d rd=%0d data=%h", s, r, dout);
    checks++; if (s !== 3) begin errors++; $display("FAIL miss_stall_cycles: got %0d, expected 3", s); end
    checks++; if (r !== 2 || w !== 0) begin errors++; $display("FAIL miss_mem_cycles: got rd=%0d wr=%0d, expected 2/0", r, w); end
    checks++; if (dout !== 32'h11223344) begin errors++; $display("FAIL miss_data: got %h, expected 11223344", dout); end
    checks++; if (ma !== 32'h40) begin errors++; $display("FAIL miss_addr: got %h, expected 00000040", ma); end
    do_access(32'h40, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000040 hit: stalls=%0d rd=%0d data=%h", s, r, dout);
    checks++; if (s !== 0 || r !== 0) begin errors++; $display("FAIL rehit_latency: got stalls=%0d rd=%0d, expected 0/0", s, r); end
    checks++; if (dout !== 32'h11223344) begin errors++; $display("FAIL rehit_data: got %h, expected 11223344", dout); end
  endtask

  task automatic test_write_hit();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    do_access(32'h40, 1'b0, 1'b1, 32'hDEADBEEF, s, r, w, dout, ma, md, both);
    $display("write 0x00000040 hit: stalls=%0d wr=%0d addr=%h", s, w, ma);
    checks++; if (s !== 3 || w !== 2 || r !== 0) begin errors++; $display("FAIL wrhit_cycles: got stalls=%0d wr=%0d rd=%0d, expected 3/2/0", s, w, r); end
    checks++; if (ma !== 32'h40 || md !== 32'hDEADBEEF) begin errors++; $display("FAIL wrhit_bus: got addr=%h data=%h, expected 00000040/deadbeef", ma, md); end
    checks++; if (get_word(32'h40) !== 32'hDEADBEEF) begin errors++; $display("FAIL wrhit_memory: got %h, expected deadbeef", get_word(32'h40)); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL wrhit_done_data: got %h, expected 0", dout); end
    do_access(32'h40, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000040 hit: stalls=%0d data=%h", s, dout);
    checks++; if (s !== 0 || r !== 0 || dout !== 32'hDEADBEEF) begin errors++; $display("FAIL wrhit_readback: got stalls=%0d rd=%0d data=%h, expected 0/0/deadbeef", s, r, dout); end
  endtask

  task automatic test_write_miss();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    do_access(32'h100, 1'b0, 1'b1, 32'hCAFEF00D, s, r, w, dout, ma, md, both);
    $display("write 0x00000100 miss: stalls=%0d wr=%0d", s, w);
    checks++; if (w !== 2 || get_word(32'h100) !== 32'hCAFEF00D) begin errors++; $display("FAIL wrmiss_memory: got wr=%0d mem=%h, expected 2/cafef00d", w, get_word(32'h100)); end
    do_access(32'h100, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000100 miss: stalls=%0d rd=%0d data=%h", s, r, dout);
    checks++; if (s !== 3 || r !== 2) begin errors++; $display("FAIL wrmiss_no_alloc: got stalls=%0d rd=%0d, expected 3/2", s, r); end
    checks++; if (dout !== 32'hCAFEF00D) begin errors++; $display("FAIL wrmiss_data: got %h, expected cafef00d", dout); end
  endtask

  task automatic test_conflict();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    addrs[0] = 32'h40;  exp[0] = 32'hDEADBEEF;
    addrs[1] = 32'h140; exp[1] = 32'h55667788;
    addrs[2] = 32'h40;  exp[2] = 32'hDEADBEEF;
    set_word(32'h140, 32'h55667788);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_access(addrs[i], 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
      $display("read  %h conflict: stalls=%0d rd=%0d data=%h", addrs[i], s, r, dout);
      checks++; if (r !== 2 || dout !== exp[i]) begin errors++; $display("FAIL conflict_%0d: got rd=%0d data=%h, expected 2/%h", i, r, dout, exp[i]); end
    end
  endtask

  task automatic test_read_write_both();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    apply_reset();
    do_access(32'h43, 1'b1, 1'b1, 32'h12345678, s, r, w, dout, ma, md, both);
    $display("rd+wr 0x00000043: rd=%0d wr=%0d addr=%h data=%h", r, w, ma, dout);
    checks++; if (w !== 0 || r !== 2 || both !== 1'b0) begin errors++; $display("FAIL rw_enables: got rd=%0d wr=%0d both=%b, expected 2/0/0", r, w, both); end
    checks++; if (ma !== 32'h40) begin errors++; $display("FAIL rw_addr: got %h, expected 00000040", ma); end
    checks++; if (dout !== 32'hDEADBEEF || get_word(32'h40) !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_data: got %h mem=%h, expected deadbeef/deadbeef", dout, get_word(32'h40)); end
  endtask

  task automatic test_reset_mid_miss();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    cpuAddress = 32'h100; cpuRead = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (memReadEnable !== 1'b1) begin errors++; $display("FAIL midmiss_enter: got rd_en=%b, expected 1", memReadEnable); end
    reset = 1'b1;
    #1;
    $display("reset mid-miss: rd_en=%b stall=%b", memReadEnable, cpuStall);
    checks++; if (memReadEnable !== 1'b0 || cpuStall !== 1'b0) begin errors++; $display("FAIL midmiss_async: got rd_en=%b stall=%b, expected 0/0", memReadEnable, cpuStall); end
    @(posedge clk);
    #1;
    reset = 1'b0; cpuRead = 1'b0; cpuAddress = 32'h0;
    do_access(32'h100, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000100 after reset: rd=%0d data=%h", r, dout);
    checks++; if (r !== 2 || dout !== 32'hCAFEF00D) begin errors++; $display("FAIL midmiss_refetch: got rd=%0d data=%h, expected 2/cafef00d", r, dout); end
  endtask

  task automatic test_back_to_back();
    int s, r, w; logic [31:0] dout, ma, md; logic both;
    do_access(32'h100, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0x00000100 hit: stalls=%0d data=%h", s, dout);
    checks++; if (s !== 0 || dout !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_hit: got stalls=%0d data=%h, expected 0/cafef00d", s, dout); end
    do_access(32'hFFFFFFFC, 1'b0, 1'b1, 32'hA5A55A5A, s, r, w, dout, ma, md, both);
    $display("write 0xfffffffc: wr=%0d addr=%h", w, ma);
    checks++; if (w !== 2 || ma !== 32'hFFFFFFFC || md !== 32'hA5A55A5A) begin errors++; $display("FAIL wrap_write: got wr=%0d addr=%h data=%h, expected 2/fffffffc/a5a55a5a", w, ma, md); end
    do_access(32'hFFFFFFFC, 1'b1, 1'b0, 32'h0, s, r, w, dout, ma, md, both);
    $display("read  0xfffffffc: rd=%0d data=%h", r, dout);
    checks++; if (r !== 2 || dout !== 32'hA5A55A5A) begin errors++; $display("FAIL wrap_read: got rd=%0d data=%h, expected 2/a5a55a5a", r, dout); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    set_word(32'h40, 32'h11223344);
    test_reset();
    test_read_miss();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_read_write_both();
    test_reset_mid_miss();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
